// File: rtl/msdap_pkg.sv
// Shared types and helpers for the MSDAP load/run sequencer.
package msdap_pkg;

   typedef enum logic [3:0] {
      ST_CLEAR,
      ST_WAIT_RJ,
      ST_LOAD_RJ,
      ST_WAIT_CO,
      ST_LOAD_CO,
      ST_WAIT_DATA,
      ST_RUN,
      ST_SLEEP,
      ST_FLUSH
   } seq_state_t;

   localparam int DEF_NUM_CH       = 2;
   localparam int DEF_NUM_RJ       = 16;
   localparam int DEF_NUM_COEFF    = 512;
   localparam int DEF_IN_DEPTH     = 512;
   localparam int DEF_SLEEP_THRESH = 800;

   // Smallest n with 2**n >= value.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

   // Address width that never collapses to zero bits.
   function automatic int addr_width(input int depth);
      return (clog2(depth) < 1) ? 1 : clog2(depth);
   endfunction

endpackage

// File: rtl/msdap_zero_det.sv
// Counts consecutive all-zero frames and flags the frame that reaches the
// sleep threshold. The count saturates at the threshold so long silences
// never wrap back to zero.
module msdap_zero_det
   import msdap_pkg::*;
#(
   parameter  int NUM_CH       = DEF_NUM_CH,
   parameter  int SLEEP_THRESH = DEF_SLEEP_THRESH,
   localparam int CW           = clog2(SLEEP_THRESH + 1)
) (
   input  logic              Sclk,
   input  logic              Reset_n,
   input  logic              clr,
   input  logic              frame,
   input  logic [NUM_CH-1:0] word_zero,
   output logic              hit
);

   logic          all_zero;
   logic [CW-1:0] zero_count;

   assign all_zero = &word_zero;

   // The current frame is the threshold-th zero frame in a row.
   assign hit = frame && all_zero && (zero_count >= CW'(SLEEP_THRESH - 1));

   // Track the run length of all-zero frames; any non-zero word restarts it.
   always_ff @(posedge Sclk or negedge Reset_n) begin
      if (!Reset_n) begin
         zero_count <= '0;
      end else if (clr) begin
         zero_count <= '0;
      end else if (frame) begin
         if (!all_zero) begin
            zero_count <= '0;
         end else if (zero_count != CW'(SLEEP_THRESH)) begin
            zero_count <= zero_count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/msdap_seq_ctrl.sv
// Load/run sequencer: steers S2P frames into the rj, coefficient and input
// RAM write ports, then launches one ALU computation per input sample.
// Write enables follow frame_vld in the same cycle; everything else is
// registered.
module msdap_seq_ctrl
   import msdap_pkg::*;
#(
   parameter  int NUM_CH       = DEF_NUM_CH,
   parameter  int NUM_RJ       = DEF_NUM_RJ,
   parameter  int NUM_COEFF    = DEF_NUM_COEFF,
   parameter  int IN_DEPTH     = DEF_IN_DEPTH,
   parameter  int SLEEP_THRESH = DEF_SLEEP_THRESH,
   localparam int RJ_AW        = addr_width(NUM_RJ),
   localparam int CO_AW        = addr_width(NUM_COEFF),
   localparam int IN_AW        = addr_width(IN_DEPTH)
) (
   input  logic              Sclk,
   input  logic              Reset_n,
   input  logic              Start,
   input  logic              flush_n,
   input  logic              frame_vld,
   input  logic [NUM_CH-1:0] word_zero,
   input  logic              alu_busy,
   output logic              InReady,
   output logic              clear,
   output logic              rj_we,
   output logic [RJ_AW-1:0]  rj_addr,
   output logic              coeff_we,
   output logic [CO_AW-1:0]  coeff_addr,
   output logic              in_we,
   output logic [IN_AW-1:0]  in_addr,
   output logic              alu_start,
   output logic [IN_AW-1:0]  alu_base,
   output logic              sleep,
   output logic              overrun
);

   seq_state_t state;

   logic rj_phase;
   logic co_phase;
   logic data_phase;
   logic frame_taken;
   logic zero_hit;
   logic zero_clr;
   logic any_nonzero;

   assign rj_phase    = (state == ST_WAIT_RJ) || (state == ST_LOAD_RJ);
   assign co_phase    = (state == ST_WAIT_CO) || (state == ST_LOAD_CO);
   assign data_phase  = (state == ST_WAIT_DATA) || (state == ST_RUN) || (state == ST_SLEEP);
   assign any_nonzero = ~&word_zero;

   // Start beats flush beats frame, so a frame arriving with either is dropped.
   assign rj_we       = frame_vld && !Start && rj_phase;
   assign coeff_we    = frame_vld && !Start && co_phase;
   assign in_we       = frame_vld && !Start && data_phase && flush_n;
   assign frame_taken = rj_we || coeff_we || in_we;

   assign zero_clr = Start || (state == ST_CLEAR) || (state == ST_FLUSH);

   msdap_zero_det #(
      .NUM_CH       (NUM_CH),
      .SLEEP_THRESH (SLEEP_THRESH)
   ) u_zero_det (
      .Sclk      (Sclk),
      .Reset_n   (Reset_n),
      .clr       (zero_clr),
      .frame     (frame_taken),
      .word_zero (word_zero),
      .hit       (zero_hit)
   );

   // Main sequencer: state, address counters, ALU launch and sticky overrun.
   always_ff @(posedge Sclk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= ST_CLEAR;
         InReady    <= 1'b0;
         clear      <= 1'b0;
         rj_addr    <= '0;
         coeff_addr <= '0;
         in_addr    <= '0;
         alu_start  <= 1'b0;
         alu_base   <= '0;
         sleep      <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         clear     <= 1'b0;
         alu_start <= 1'b0;
         if (Start) begin
            state      <= ST_CLEAR;
            InReady    <= 1'b0;
            rj_addr    <= '0;
            coeff_addr <= '0;
            in_addr    <= '0;
            alu_base   <= '0;
            sleep      <= 1'b0;
            overrun    <= 1'b0;
         end else begin
            case (state)
               ST_CLEAR: begin
                  state   <= ST_WAIT_RJ;
                  clear   <= 1'b1;
                  InReady <= 1'b1;
               end
               ST_WAIT_RJ, ST_LOAD_RJ: begin
                  if (rj_we) begin
                     if (rj_addr == RJ_AW'(NUM_RJ - 1)) begin
                        rj_addr <= '0;
                        state   <= ST_WAIT_CO;
                     end else begin
                        rj_addr <= rj_addr + 1'b1;
                        state   <= ST_LOAD_RJ;
                     end
                  end
               end
               ST_WAIT_CO, ST_LOAD_CO: begin
                  if (coeff_we) begin
                     if (coeff_addr == CO_AW'(NUM_COEFF - 1)) begin
                        coeff_addr <= '0;
                        state      <= ST_WAIT_DATA;
                     end else begin
                        coeff_addr <= coeff_addr + 1'b1;
                        state      <= ST_LOAD_CO;
                     end
                  end
               end
               ST_WAIT_DATA, ST_RUN, ST_SLEEP: begin
                  if (!flush_n) begin
                     state   <= ST_FLUSH;
                     clear   <= 1'b1;
                     InReady <= 1'b0;
                     in_addr <= '0;
                     sleep   <= 1'b0;
                  end else if (in_we) begin
                     in_addr  <= in_addr + 1'b1;
                     alu_base <= in_addr;
                     if ((state == ST_RUN) && alu_busy) begin
                        overrun <= 1'b1;
                     end
                     if (state == ST_SLEEP) begin
                        if (any_nonzero) begin
                           state     <= ST_RUN;
                           sleep     <= 1'b0;
                           alu_start <= 1'b1;
                        end
                     end else if ((state == ST_RUN) && zero_hit) begin
                        state <= ST_SLEEP;
                        sleep <= 1'b1;
                     end else begin
                        state     <= ST_RUN;
                        alu_start <= 1'b1;
                     end
                  end
               end
               ST_FLUSH: begin
                  if (flush_n) begin
                     state   <= ST_WAIT_DATA;
                     InReady <= 1'b1;
                     in_addr <= '0;
                  end
               end
               default: begin
                  state <= ST_CLEAR;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_msdap_seq_ctrl.sv
// Directed bench for msdap_seq_ctrl: load sequencing, restart, circular
// input addressing, sleep/wake, overrun, flush and async reset.
module tb_msdap_seq_ctrl;

   logic       Sclk;
   logic       Reset_n;
   logic       Start;
   logic       flush_n;
   logic       frame_vld;
   logic [1:0] word_zero;
   logic       alu_busy;
   logic       InReady;
   logic       clear;
   logic       rj_we;
   logic [3:0] rj_addr;
   logic       coeff_we;
   logic [8:0] coeff_addr;
   logic       in_we;
   logic [8:0] in_addr;
   logic       alu_start;
   logic [8:0] alu_base;
   logic       sleep;
   logic       overrun;

   int errors = 0;
   int checks = 0;
   int starts = 0;
   int clears = 0;

   msdap_seq_ctrl #(
      .NUM_CH       (2),
      .NUM_RJ       (16),
      .NUM_COEFF    (512),
      .IN_DEPTH     (512),
      .SLEEP_THRESH (8)
   ) dut (
      .Sclk       (Sclk),
      .Reset_n    (Reset_n),
      .Start      (Start),
      .flush_n    (flush_n),
      .frame_vld  (frame_vld),
      .word_zero  (word_zero),
      .alu_busy   (alu_busy),
      .InReady    (InReady),
      .clear      (clear),
      .rj_we      (rj_we),
      .rj_addr    (rj_addr),
      .coeff_we   (coeff_we),
      .coeff_addr (coeff_addr),
      .in_we      (in_we),
      .in_addr    (in_addr),
      .alu_start  (alu_start),
      .alu_base   (alu_base),
      .sleep      (sleep),
      .overrun    (overrun)
   );

   // Free-running 100 MHz system clock.
   initial Sclk = 1'b0;
   always #5 Sclk = ~Sclk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs just after the rising edge, then settle at the
   // falling edge where outputs are sampled.
   task automatic applyStimulus(input logic fv, input logic [1:0] wz, input logic busy,
                                input logic fl, input logic st);
      @(posedge Sclk);
      #1;
      frame_vld = fv;
      word_zero = wz;
      alu_busy  = busy;
      flush_n   = fl;
      Start     = st;
      @(negedge Sclk);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic sendFrame(input logic [1:0] wz);
      applyStimulus(1'b1, wz, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic loadRj();
      for (int i = 0; i < 16; i++) begin
         sendFrame(2'b00);
         checkOutput("rj_we", 32'(rj_we), 1);
         checkOutput("rj_addr", 32'(rj_addr), i);
         checkOutput("rj_no_coeff_we", 32'(coeff_we), 0);
      end
   endtask

   task automatic loadCoeff(input int count);
      for (int i = 0; i < count; i++) begin
         sendFrame(2'b00);
         checkOutput("coeff_we", 32'(coeff_we), 1);
         checkOutput("coeff_addr", 32'(coeff_addr), i);
         checkOutput("coeff_no_rj_we", 32'(rj_we), 0);
      end
   endtask

   initial begin
      Reset_n   = 1'b0;
      Start     = 1'b0;
      flush_n   = 1'b1;
      frame_vld = 1'b0;
      word_zero = 2'b00;
      alu_busy  = 1'b0;
      #12;
      checkOutput("reset_flags", 32'({clear, InReady, rj_we, coeff_we, in_we,
                                      alu_start, sleep, overrun}), 0);
      checkOutput("reset_addrs", 32'({rj_addr, coeff_addr, in_addr, alu_base}), 0);
      Reset_n = 1'b1;

      idle();
      checkOutput("post_reset_clear", 32'(clear), 1);
      checkOutput("post_reset_inready", 32'(InReady), 1);
      idle();
      checkOutput("clear_one_cycle", 32'(clear), 0);

      loadRj();
      loadCoeff(100);

      // Restart in the middle of the coefficient load
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
      checkOutput("start_blocks_coeff_we", 32'(coeff_we), 0);
      checkOutput("start_coeff_addr", 32'(coeff_addr), 100);
      idle();
      checkOutput("restart_inready", 32'(InReady), 0);
      checkOutput("restart_clear_wait", 32'(clear), 0);
      idle();
      checkOutput("restart_clear", 32'(clear), 1);
      checkOutput("restart_rj_addr", 32'(rj_addr), 0);
      checkOutput("restart_coeff_addr", 32'(coeff_addr), 0);

      loadRj();
      loadCoeff(512);
      idle();
      checkOutput("wait_data_inready", 32'(InReady), 1);
      checkOutput("wait_data_no_start", 32'(alu_start), 0);
      checkOutput("wait_data_in_addr", 32'(in_addr), 0);

      // 600 non-zero data frames, wrapping the input buffer once
      for (int k = 0; k < 600; k++) begin
         sendFrame(2'b01);
         checkOutput("run_in_we", 32'(in_we), 1);
         checkOutput("run_in_addr", 32'(in_addr), k % 512);
         if (k > 0) begin
            checkOutput("run_alu_start", 32'(alu_start), 1);
            checkOutput("run_alu_base", 32'(alu_base), (k - 1) % 512);
         end else begin
            checkOutput("first_alu_start", 32'(alu_start), 0);
         end
         if (alu_start) starts++;
      end
      idle();
      if (alu_start) starts++;
      checkOutput("last_alu_base", 32'(alu_base), 87);
      checkOutput("alu_start_count", 32'(starts), 600);
      checkOutput("wrap_next_addr", 32'(in_addr), 88);

      // Eight all-zero frames push RUN into SLEEP
      for (int j = 0; j < 8; j++) begin
         sendFrame(2'b11);
         checkOutput("silence_in_addr", 32'(in_addr), 88 + j);
         checkOutput("silence_alu_start", 32'(alu_start), (j == 0) ? 0 : 1);
         checkOutput("silence_sleep", 32'(sleep), 0);
      end
      idle();
      checkOutput("sleep_entered", 32'(sleep), 1);
      checkOutput("sleep_no_alu_start", 32'(alu_start), 0);
      sendFrame(2'b11);
      checkOutput("sleep_still_writes", 32'(in_we), 1);
      checkOutput("sleep_write_addr", 32'(in_addr), 96);
      sendFrame(2'b10);
      checkOutput("wake_write_addr", 32'(in_addr), 97);
      checkOutput("sleep_zero_frame_no_start", 32'(alu_start), 0);
      checkOutput("sleep_held", 32'(sleep), 1);
      idle();
      checkOutput("wake_sleep_low", 32'(sleep), 0);
      checkOutput("wake_alu_start", 32'(alu_start), 1);
      checkOutput("wake_alu_base", 32'(alu_base), 97);

      // Frame while the ALU is busy
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
      checkOutput("busy_frame_written", 32'(in_we), 1);
      checkOutput("busy_frame_addr", 32'(in_addr), 98);
      checkOutput("overrun_before", 32'(overrun), 0);
      idle();
      checkOutput("overrun_set", 32'(overrun), 1);
      checkOutput("busy_alu_base", 32'(alu_base), 98);
      sendFrame(2'b01);
      idle();
      checkOutput("overrun_sticky", 32'(overrun), 1);

      // Flush held low for ten cycles, first cycle carries a frame
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
      checkOutput("flush_drops_frame", 32'(in_we), 0);
      for (int f = 1; f < 10; f++) begin
         applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
         checkOutput("flush_inready", 32'(InReady), 0);
         checkOutput("flush_no_write", 32'(in_we), 0);
         if (clear) clears++;
      end
      idle();
      if (clear) clears++;
      checkOutput("flush_exit_pending", 32'(InReady), 0);
      idle();
      if (clear) clears++;
      checkOutput("flush_exit_inready", 32'(InReady), 1);
      checkOutput("flush_clear_count", 32'(clears), 1);
      sendFrame(2'b01);
      checkOutput("post_flush_we", 32'(in_we), 1);
      checkOutput("post_flush_addr", 32'(in_addr), 0);
      checkOutput("overrun_survives_flush", 32'(overrun), 1);
      idle();
      checkOutput("post_flush_alu_start", 32'(alu_start), 1);
      checkOutput("post_flush_alu_base", 32'(alu_base), 0);

      // Start clears the sticky overrun and restarts loading
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
      checkOutput("overrun_before_start", 32'(overrun), 1);
      idle();
      checkOutput("start_clears_overrun", 32'(overrun), 0);
      checkOutput("start_inready", 32'(InReady), 0);
      idle();
      checkOutput("start_clear_pulse", 32'(clear), 1);

      loadRj();
      loadCoeff(512);
      sendFrame(2'b01);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
      sendFrame(2'b01);
      checkOutput("pre_reset_active", 32'({in_we, alu_start, overrun}), 32'b111);
      checkOutput("pre_reset_in_addr", 32'(in_addr), 2);

      // Asynchronous reset mid-cycle while a frame is being written
      #2;
      Reset_n = 1'b0;
      #1;
      checkOutput("async_reset_flags", 32'({clear, InReady, rj_we, coeff_we, in_we,
                                            alu_start, sleep, overrun}), 0);
      checkOutput("async_reset_addrs", 32'({rj_addr, coeff_addr, in_addr, alu_base}), 0);
      #10;
      Reset_n = 1'b1;
      idle();
      checkOutput("reset_again_clear", 32'(clear), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
